// File: rtl/sorter_pkg.sv
// sorter_pkg: default sizes and the signed/unsigned compare shared by the sorter.
package sorter_pkg;
  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_MAX_DATALENGTH = 32;
  localparam int CMP_W = 64;
  function automatic logic gt(input logic sign, input logic [CMP_W-1:0] a, input logic [CMP_W-1:0] b);
    return sign ? ($signed(a) > $signed(b)) : (a > b);
  endfunction
endpackage

// File: rtl/sorter_cas.sv
// sorter_cas: one compare-exchange node; dir=1 puts the larger key on hi.
module sorter_cas
  import sorter_pkg::*;
#(
  parameter int W = DEF_DATAWIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sign,
  input  logic         dir,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  logic [CMP_W-1:0] ae;
  logic [CMP_W-1:0] be;
  logic             agt;
  // widen so one compare function serves both modes; assumes W < CMP_W
  assign ae  = {{(CMP_W-W){sign & a[W-1]}}, a};
  assign be  = {{(CMP_W-W){sign & b[W-1]}}, b};
  assign agt = gt(sign, ae, be);
  assign hi  = (agt == dir) ? a : b;
  assign lo  = (agt == dir) ? b : a;
endmodule

// File: rtl/sorter_top.sv
// sorter_top: two-stage pipelined bitonic sorter, descending, with length masking.
module sorter_top
  import sorter_pkg::*;
#(
  parameter int DATAWIDTH      = DEF_DATAWIDTH,
  parameter int MAX_DATALENGTH = DEF_MAX_DATALENGTH
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 sign_ctrl_i,
  input  logic [5:0]           in_data_length_i,
  input  logic [DATAWIDTH-1:0] x_i [MAX_DATALENGTH-1:0],
  output logic [DATAWIDTH-1:0] y_o [MAX_DATALENGTH-1:0]
);
  localparam int M  = MAX_DATALENGTH;
  localparam int L  = $clog2(M);
  localparam int S  = L * (L + 1) / 2;
  localparam int NW = 7;
  localparam logic [DATAWIDTH-1:0] SMIN = {1'b1, {(DATAWIDTH-1){1'b0}}};
  logic                 sign_q;
  logic [NW-1:0]        n_in;
  logic [NW-1:0]        n_q;
  logic [DATAWIDTH-1:0] x_q [M];
  logic [DATAWIDTH-1:0] net [S+1][M];
  assign n_in = ({1'b0, in_data_length_i} > NW'(M)) ? NW'(M) : {1'b0, in_data_length_i};
  // padding lanes take the mode's minimum so they sink below every valid element
  for (genvar i = 0; i < M; i++) begin : g_pad
    assign net[0][i] = (NW'(i) < n_q) ? x_q[i] : (sign_q ? SMIN : '0);
  end
  for (genvar p = 1; p <= L; p++) begin : g_p
    for (genvar q = p - 1; q >= 0; q--) begin : g_q
      localparam int SI = p * (p - 1) / 2 + (p - 1 - q);
      localparam int J  = 1 << q;
      for (genvar i = 0; i < M; i++) begin : g_i
        if ((i & J) == 0) begin : g_n
          sorter_cas #(.W(DATAWIDTH)) u_cas (
            .a   (net[SI][i]),
            .b   (net[SI][i+J]),
            .sign(sign_q),
            .dir (((i >> p) & 1) == 0),
            .hi  (net[SI+1][i]),
            .lo  (net[SI+1][i+J])
          );
        end
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      sign_q <= 1'b0;
      n_q    <= '0;
      for (int i = 0; i < M; i++) begin
        x_q[i] <= '0;
        y_o[i] <= '0;
      end
    end else begin
      sign_q <= sign_ctrl_i;
      n_q    <= n_in;
      for (int i = 0; i < M; i++) begin
        x_q[i] <= x_i[i];
        y_o[i] <= (NW'(i) < n_q) ? net[S][i] : '0;
      end
    end
  end
endmodule

// File: tb/tb_sorter_top.sv
// tb_sorter_top: random and directed vectors against a queue scoreboard fed by a sorting model.
module tb_sorter_top;
  localparam int W = 8;
  localparam int M = 32;
  typedef struct packed {
    logic [31:0]    due;
    logic [M*W-1:0] v;
  } exp_t;
  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         sign_ctrl_i;
  logic [5:0]   in_data_length_i;
  logic [W-1:0] x_i [M-1:0];
  logic [W-1:0] y_o [M-1:0];
  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cnt = 0;
  int           e = 1;
  logic           p_rst = 1'b1;
  logic           p_s = 1'b0;
  logic [5:0]     p_n = '0;
  logic [M*W-1:0] p_x = '0;

  sorter_top #(.DATAWIDTH(W), .MAX_DATALENGTH(M)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .sign_ctrl_i     (sign_ctrl_i),
    .in_data_length_i(in_data_length_i),
    .x_i             (x_i),
    .y_o             (y_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int key(input logic s, input logic [W-1:0] v);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  // reference: take the first N values, selection-sort descending, zero-fill the rest
  function automatic logic [M*W-1:0] model(input logic s, input logic [5:0] n6, input logic [M*W-1:0] xv);
    logic [W-1:0]   a [M];
    logic [W-1:0]   t;
    logic [M*W-1:0] r;
    int             n;
    int             b;
    n = (n6 > 6'd32) ? 32 : int'(n6);
    r = '0;
    for (int i = 0; i < M; i++) a[i] = xv[i*W +: W];
    for (int i = 0; i < n; i++) begin
      b = i;
      for (int j = i + 1; j < n; j++) if (key(s, a[j]) > key(s, a[b])) b = j;
      t = a[i]; a[i] = a[b]; a[b] = t;
      r[i*W +: W] = a[i];
    end
    return r;
  endfunction

  function automatic logic [M*W-1:0] rnd_vec();
    logic [M*W-1:0] v;
    for (int i = 0; i < M; i++) v[i*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic step(input logic r, input logic s, input logic [5:0] n, input logic [M*W-1:0] xv);
    exp_t ex;
    rstn_i = r;
    sign_ctrl_i = s;
    in_data_length_i = n;
    for (int i = 0; i < M; i++) x_i[i] = xv[i*W +: W];
    ex.due = 32'(e);
    ex.v = (r || p_rst) ? '0 : model(p_s, p_n, p_x);
    sb.push_back(ex);
    p_rst = r; p_s = s; p_n = n; p_x = xv;
    e++;
    @(posedge clk_i);
    #1;
  endtask

  initial forever begin
    @(posedge clk_i);
    cnt++;
  end

  initial forever begin
    logic [M*W-1:0] got;
    exp_t ex;
    @(negedge clk_i);
    if (sb.size() > 0 && int'(sb[0].due) == cnt) begin
      ex = sb.pop_front();
      for (int i = 0; i < M; i++) got[i*W +: W] = y_o[i];
      total++;
      if (got !== ex.v) begin
        bad++;
        $display("FAIL y_o edge=%0d got=%h want=%h", cnt, got, ex.v);
      end
    end
  end

  initial begin
    int             a23 [32] = '{5,7,9,1,0,2,3,6,8,15,14,12,13,10,11,4,7,5,9,6,4,2,0,3,5,6,12,5,8,5,7,15};
    int             a25 [8]  = '{15,7,5,8,5,12,6,5};
    int             n27 [11] = '{32,32,18,20,16,14,11,8,6,4,3};
    logic [M*W-1:0] v;
    logic [W-1:0]   t;
    int             k;
    step(1, 0, 6'd32, rnd_vec());
    step(1, 1, 6'd32, rnd_vec());
    for (int i = 0; i < M; i++) v[(31-i)*W +: W] = W'(a23[i]);
    step(0, 0, 6'd32, v);
    v = '0;
    v[0*W +: W] = 8'd56;  v[1*W +: W] = 8'd35;  v[2*W +: W] = 8'd25;
    v[3*W +: W] = 8'd25;  v[4*W +: W] = 8'd23;  v[5*W +: W] = 8'hA1;
    v[6*W +: W] = 8'h9C;  v[7*W +: W] = 8'h9C;  v[8*W +: W] = 8'hFF;
    for (int i = 9; i < M; i++) v[i*W +: W] = W'($urandom_range(118) - 95);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(M - 1);
      t = v[0*W +: W]; v[0*W +: W] = v[k*W +: W]; v[k*W +: W] = t;
    end
    step(0, 1, 6'd32, v);
    step(0, 0, 6'd32, v);
    for (int i = 0; i < M; i++) v[i*W +: W] = W'($urandom_range(255, 1));
    for (int i = 0; i < 8; i++) v[i*W +: W] = W'(a25[i]);
    step(0, 0, 6'd8, v);
    v = rnd_vec();
    v[0*W +: W] = 8'd9; v[1*W +: W] = 8'd7; v[2*W +: W] = 8'd5;
    step(0, 0, 6'd3, v);
    step(0, 1, 6'd0, rnd_vec());
    for (int i = 0; i < 11; i++) step(0, i[0], 6'(n27[i]), rnd_vec());
    for (int i = 0; i < 150; i++) step(0, 1'($urandom), 6'($urandom), rnd_vec());
    for (int i = 0; i < 40; i++) step(0, 1'($urandom), 6'($urandom_range(32)), rnd_vec());
    step(1, 0, 6'd32, rnd_vec());
    for (int i = 0; i < 5; i++) step(0, 1'($urandom), 6'($urandom_range(32)), rnd_vec());
    step(1, 1, 6'd32, rnd_vec());
    step(1, 0, 6'd32, rnd_vec());
    for (int i = 0; i < 20; i++) step(0, 1'($urandom), 6'($urandom_range(32)), rnd_vec());
    for (int i = 0; i < 3; i++) step(0, 0, 6'd32, rnd_vec());
    repeat (2) @(negedge clk_i);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
